// File: rtl/cond_branch_seq.sv
// Conditional branch sequencer: tracks outstanding flag writers, waits for
// older ALU ops to retire their flags, then resolves the branch condition.
module cond_branch_seq #(
    parameter int MAX_PEND = 3,
    parameter int CNT_W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_issue_i,
    input  logic             flag_wr_i,
    input  logic             flag_z_i,
    input  logic             flag_n_i,
    input  logic             flag_v_i,
    input  logic             flag_c_i,
    input  logic             flag_a0_i,
    input  logic             br_req_i,
    input  logic [4:0]       br_cond_i,
    output logic             br_rdy_o,
    output logic             res_vld_o,
    output logic             res_taken_o,
    output logic             res_err_o,
    input  logic             res_ack_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [CNT_W-1:0] pend_cnt_o,
    output logic [1:0]       err_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PEND);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] pendCnt;
    logic [CNT_W-1:0] pendNext;
    logic [CNT_W-1:0] waitCnt;
    logic [4:0]       condReg;
    logic [1:0]       errReg;
    logic             pendOvf;
    logic             pendUnf;
    logic             flagZ;
    logic             flagN;
    logic             flagV;
    logic             flagC;
    logic             flagA0;
    logic             selHit;
    logic             selErr;
    logic             takenNext;
    logic             takenReg;
    logic             errBitReg;

    // Next pending count with saturation at both ends
    always_comb begin
        pendNext = pendCnt;
        pendOvf  = 1'b0;
        pendUnf  = 1'b0;
        if (alu_issue_i && !flag_wr_i) begin
            if (pendCnt == MAX_CNT) begin
                pendOvf = 1'b1;
            end else begin
                pendNext = pendCnt + ONE;
            end
        end else if (!alu_issue_i && flag_wr_i) begin
            if (pendCnt == '0) begin
                pendUnf = 1'b1;
            end else begin
                pendNext = pendCnt - ONE;
            end
        end
    end

    // Pending counter and sticky error bits; flush never touches them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pendCnt <= '0;
            errReg  <= 2'b00;
        end else begin
            pendCnt <= pendNext;
            errReg  <= errReg | {pendUnf, pendOvf};
        end
    end

    // Architectural flag register, loaded on every flag write-back
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flagZ  <= 1'b0;
            flagN  <= 1'b0;
            flagV  <= 1'b0;
            flagC  <= 1'b0;
            flagA0 <= 1'b0;
        end else if (flag_wr_i) begin
            flagZ  <= flag_z_i;
            flagN  <= flag_n_i;
            flagV  <= flag_v_i;
            flagC  <= flag_c_i;
            flagA0 <= flag_a0_i;
        end
    end

    // Condition select decode against the registered flags only
    always_comb begin
        selHit = 1'b0;
        selErr = 1'b0;
        unique case (condReg[3:0])
            4'd0:    selHit = 1'b1;
            4'd1:    selHit = flagZ;
            4'd2:    selHit = flagN;
            4'd3:    selHit = flagV;
            4'd4:    selHit = flagC;
            4'd5:    selHit = flagN ^ flagV;
            4'd6:    selHit = flagZ | (flagN ^ flagV);
            4'd7:    selHit = flagC & ~flagZ;
            4'd8:    selHit = flagA0;
            default: selErr = 1'b1;
        endcase
        takenNext = selErr ? 1'b0 : (selHit ^ condReg[4]);
    end

    // Branch FSM: capture, wait for older flag writers, resolve, hand off
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            waitCnt   <= '0;
            condReg   <= 5'd0;
            takenReg  <= 1'b0;
            errBitReg <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (br_req_i) begin
                        condReg <= br_cond_i;
                        waitCnt <= pendNext;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else if (waitCnt != '0) begin
                        if (flag_wr_i) begin
                            waitCnt <= waitCnt - ONE;
                        end
                    end else begin
                        takenReg  <= takenNext;
                        errBitReg <= selErr;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (flush_i) begin
                        takenReg  <= 1'b0;
                        errBitReg <= 1'b0;
                        state     <= IDLE;
                    end else if (res_ack_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign br_rdy_o    = (state == IDLE);
    assign stall_o     = (state == WAIT);
    assign res_vld_o   = (state == RESP);
    assign res_taken_o = takenReg;
    assign res_err_o   = errBitReg;
    assign pend_cnt_o  = pendCnt;
    assign err_o       = errReg;

endmodule

// File: tb/tb_cond_branch_seq.sv
// Bench for cond_branch_seq: directed stimulus, results checked by a
// scoreboard monitor that pops expected {taken,err} on each new result.
module tb_cond_branch_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_issue_i;
    logic       flag_wr_i;
    logic       flag_z_i;
    logic       flag_n_i;
    logic       flag_v_i;
    logic       flag_c_i;
    logic       flag_a0_i;
    logic       br_req_i;
    logic [4:0] br_cond_i;
    logic       br_rdy_o;
    logic       res_vld_o;
    logic       res_taken_o;
    logic       res_err_o;
    logic       res_ack_i;
    logic       flush_i;
    logic       stall_o;
    logic [1:0] pend_cnt_o;
    logic [1:0] err_o;

    int checks = 0;
    int errors = 0;

    logic [1:0] expQ[$];
    logic [1:0] cur;
    logic       have = 1'b0;

    cond_branch_seq #(
        .MAX_PEND(3),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .alu_issue_i(alu_issue_i),
        .flag_wr_i(flag_wr_i),
        .flag_z_i(flag_z_i),
        .flag_n_i(flag_n_i),
        .flag_v_i(flag_v_i),
        .flag_c_i(flag_c_i),
        .flag_a0_i(flag_a0_i),
        .br_req_i(br_req_i),
        .br_cond_i(br_cond_i),
        .br_rdy_o(br_rdy_o),
        .res_vld_o(res_vld_o),
        .res_taken_o(res_taken_o),
        .res_err_o(res_err_o),
        .res_ack_i(res_ack_i),
        .flush_i(flush_i),
        .stall_o(stall_o),
        .pend_cnt_o(pend_cnt_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: pop on a fresh result, then check it stays stable
    always @(negedge clk) begin
        if (res_vld_o) begin
            if (!have) begin
                have = 1'b1;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got taken=%0b err=%0b, required no result",
                             res_taken_o, res_err_o);
                    cur = {res_taken_o, res_err_o};
                end else begin
                    cur = expQ.pop_front();
                end
            end
            checks++;
            if ({res_taken_o, res_err_o} !== cur) begin
                errors++;
                $display("FAIL result: got taken=%0b err=%0b, required taken=%0b err=%0b",
                         res_taken_o, res_err_o, cur[1], cur[0]);
            end
        end else begin
            have = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic loadFlags(input logic z, input logic n, input logic v,
                             input logic c, input logic a0);
        alu_issue_i = 1'b1;
        flag_wr_i   = 1'b1;
        flag_z_i    = z;
        flag_n_i    = n;
        flag_v_i    = v;
        flag_c_i    = c;
        flag_a0_i   = a0;
        tick();
        alu_issue_i = 1'b0;
        flag_wr_i   = 1'b0;
        {flag_z_i, flag_n_i, flag_v_i, flag_c_i, flag_a0_i} = 5'b0;
    endtask

    task automatic doBranch(input logic [4:0] c, input logic t, input logic e);
        chk("rdy_before", br_rdy_o, 1);
        expQ.push_back({t, e});
        br_req_i  = 1'b1;
        br_cond_i = c;
        tick();
        br_req_i = 1'b0;
        chk("stall_t1", stall_o, 1);
        chk("vld_t1", res_vld_o, 0);
        tick();
        chk("vld_t2", res_vld_o, 1);
        tick();
        chk("vld_hold", res_vld_o, 1);
        res_ack_i = 1'b1;
        tick();
        res_ack_i = 1'b0;
        chk("rdy_after_ack", br_rdy_o, 1);
        chk("vld_after_ack", res_vld_o, 0);
    endtask

    // {cond, taken, err} with flags Z=0 N=1 V=0 C=0 A0=1
    logic [6:0] vec[18] = '{
        {5'h00, 2'b10}, {5'h10, 2'b00}, {5'h01, 2'b00}, {5'h11, 2'b10},
        {5'h02, 2'b10}, {5'h03, 2'b00}, {5'h04, 2'b00}, {5'h14, 2'b10},
        {5'h05, 2'b10}, {5'h06, 2'b10}, {5'h16, 2'b00}, {5'h07, 2'b00},
        {5'h17, 2'b10}, {5'h08, 2'b10}, {5'h18, 2'b00}, {5'h09, 2'b01},
        {5'h0C, 2'b01}, {5'h1F, 2'b01}
    };

    initial begin
        rst_n       = 1'b0;
        alu_issue_i = 1'b0;
        flag_wr_i   = 1'b0;
        {flag_z_i, flag_n_i, flag_v_i, flag_c_i, flag_a0_i} = 5'b0;
        br_req_i    = 1'b0;
        br_cond_i   = 5'd0;
        res_ack_i   = 1'b0;
        flush_i     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_rdy", br_rdy_o, 1);
        chk("rst_stall", stall_o, 0);
        chk("rst_vld", res_vld_o, 0);
        chk("rst_pend", pend_cnt_o, 0);
        chk("rst_err", err_o, 0);

        // No pending, Z=1, condition Z
        loadFlags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("load_pend", pend_cnt_o, 0);
        chk("load_err", err_o, 0);
        doBranch(5'h01, 1'b1, 1'b0);

        // Two older writers; younger issue during the wait
        alu_issue_i = 1'b1;
        tick();
        tick();
        alu_issue_i = 1'b0;
        chk("pend_two", pend_cnt_o, 2);
        expQ.push_back(2'b10);
        br_req_i  = 1'b1;
        br_cond_i = 5'h11;
        tick();
        br_req_i = 1'b0;
        chk("w_stall0", stall_o, 1);
        alu_issue_i = 1'b1;
        flag_wr_i   = 1'b1;
        flag_z_i    = 1'b1;
        tick();
        chk("w_stall1", stall_o, 1);
        chk("w_pend1", pend_cnt_o, 2);
        alu_issue_i = 1'b0;
        flag_z_i    = 1'b0;
        tick();
        chk("w_stall2", stall_o, 1);
        chk("w_pend2", pend_cnt_o, 1);
        // Same-cycle flag write must not affect the evaluation
        alu_issue_i = 1'b1;
        flag_z_i    = 1'b1;
        tick();
        alu_issue_i = 1'b0;
        flag_wr_i   = 1'b0;
        flag_z_i    = 1'b0;
        chk("w_vld", res_vld_o, 1);
        chk("w_stall3", stall_o, 0);
        res_ack_i = 1'b1;
        tick();
        res_ack_i = 1'b0;
        chk("w_pend3", pend_cnt_o, 1);
        flag_wr_i = 1'b1;
        tick();
        flag_wr_i = 1'b0;
        chk("drain_pend", pend_cnt_o, 0);
        chk("drain_err", err_o, 0);

        // Select decode table
        loadFlags(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        foreach (vec[i]) begin
            logic [6:0] v;
            v = vec[i];
            doBranch(v[6:2], v[1], v[0]);
        end

        // Flush while waiting: no result, pending preserved
        alu_issue_i = 1'b1;
        tick();
        alu_issue_i = 1'b0;
        br_req_i    = 1'b1;
        br_cond_i   = 5'h00;
        tick();
        br_req_i = 1'b0;
        chk("fl_stall", stall_o, 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_rdy", br_rdy_o, 1);
        chk("fl_stall_off", stall_o, 0);
        chk("fl_pend", pend_cnt_o, 1);
        tick();
        tick();
        chk("fl_novld", res_vld_o, 0);

        // Flush in IDLE is ignored: request still accepted
        expQ.push_back(2'b10);
        flush_i  = 1'b1;
        br_req_i = 1'b1;
        tick();
        flush_i  = 1'b0;
        br_req_i = 1'b0;
        chk("idle_fl_stall", stall_o, 1);
        flag_wr_i = 1'b1;
        tick();
        flag_wr_i = 1'b0;
        tick();
        chk("idle_fl_vld", res_vld_o, 1);
        res_ack_i = 1'b1;
        tick();
        res_ack_i = 1'b0;

        // Reset while presenting a result
        alu_issue_i = 1'b1;
        tick();
        alu_issue_i = 1'b0;
        expQ.push_back(2'b10);
        br_req_i = 1'b1;
        tick();
        br_req_i  = 1'b0;
        flag_wr_i = 1'b1;
        tick();
        flag_wr_i   = 1'b0;
        alu_issue_i = 1'b1;
        tick();
        alu_issue_i = 1'b0;
        chk("rr_vld", res_vld_o, 1);
        chk("rr_pend", pend_cnt_o, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rr_vld_off", res_vld_o, 0);
        chk("rr_rdy", br_rdy_o, 1);
        chk("rr_pend0", pend_cnt_o, 0);
        chk("rr_err0", err_o, 0);

        // Pending overflow then underflow
        alu_issue_i = 1'b1;
        tick();
        tick();
        tick();
        chk("ov_pend3", pend_cnt_o, 3);
        chk("ov_err_none", err_o, 0);
        tick();
        alu_issue_i = 1'b0;
        chk("ov_pend_sat", pend_cnt_o, 3);
        chk("ov_err", err_o, 2'b01);
        flag_wr_i = 1'b1;
        tick();
        tick();
        tick();
        chk("un_pend0", pend_cnt_o, 0);
        chk("un_err_pre", err_o, 2'b01);
        tick();
        flag_wr_i = 1'b0;
        chk("un_pend_hold", pend_cnt_o, 0);
        chk("un_err", err_o, 2'b11);

        // Flush together with ack acts as flush
        expQ.push_back(2'b10);
        br_req_i  = 1'b1;
        br_cond_i = 5'h00;
        tick();
        br_req_i = 1'b0;
        tick();
        chk("fa_vld", res_vld_o, 1);
        flush_i   = 1'b1;
        res_ack_i = 1'b1;
        tick();
        flush_i   = 1'b0;
        res_ack_i = 1'b0;
        chk("fa_rdy", br_rdy_o, 1);
        chk("fa_vld_off", res_vld_o, 0);
        chk("fa_pend", pend_cnt_o, 0);
        tick();
        tick();

        chk("queue_empty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_branch_seq.md
COND_BRANCH_SEQ -- requirements
Module: cond_branch_seq

Interface
REQ-001 Parameter MAX_PEND, default 3, SHALL set the maximum outstanding flag-writing ALU ops (legal range 1..7).
REQ-002 Parameter CNT_W, default 2, SHALL set the pending and wait counter width, with CNT_W >= clog2(MAX_PEND+1).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 alu_issue_i  in  1  a flag-writing ALU op issues this cycle.
REQ-006 flag_wr_i  in  1  ALU flags write back this cycle (oldest op first).
REQ-007 flag_z_i, flag_n_i, flag_v_i, flag_c_i, flag_a0_i  in  1 each  zero, msb, overflow, carry, A-operand bit0.
REQ-008 br_req_i  in  1  branch condition request valid.
REQ-009 br_cond_i  in  5  condition code: [4] invert, [3:0] select.
REQ-010 br_rdy_o  out  1  request accepted when br_req_i & br_rdy_o.
REQ-011 res_vld_o / res_taken_o / res_err_o  out  1 each  result valid, branch taken, reserved code used.
REQ-012 res_ack_i  in  1  consumer takes the result.
REQ-013 flush_i  in  1  abort the in-flight branch.
REQ-014 stall_o  out  1  branch is waiting on older flag writers.
REQ-015 pend_cnt_o  out  CNT_W  outstanding flag writers.
REQ-016 err_o  out  2  sticky errors: [0] pending overflow, [1] pending underflow.

Function
REQ-017 The flag register {Z,N,V,C,A0} SHALL load from the flag inputs on every cycle flag_wr_i=1, and otherwise hold.
REQ-018 pend_cnt SHALL be next = cnt + alu_issue_i - flag_wr_i; simultaneous issue and write SHALL leave it unchanged.
REQ-019 alu_issue_i with cnt=MAX_PEND and no flag_wr_i SHALL saturate pend_cnt and set err_o[0].
REQ-020 flag_wr_i with cnt=0 and no alu_issue_i SHALL hold pend_cnt at 0, set err_o[1], and still load the flags.
REQ-021 FSM states SHALL be IDLE, WAIT, RESP; br_rdy_o=(IDLE), stall_o=(WAIT), res_vld_o=(RESP).
REQ-022 IDLE: on br_req_i, the block SHALL capture br_cond_i, load wait_cnt = pend_cnt + alu_issue_i - flag_wr_i (floor 0), and go to WAIT.
REQ-023 WAIT with wait_cnt>0: wait_cnt SHALL decrement on flag_wr_i; alu_issue_i (younger ops) SHALL NOT affect it.
REQ-024 WAIT with wait_cnt=0: the block SHALL evaluate against the registered flag register, register the result, and go to RESP; a same-cycle flag_wr_i SHALL NOT affect this result.
REQ-025 Select decode: 0 always, 1 Z, 2 N, 3 V, 4 C, 5 N^V, 6 Z|(N^V), 7 C&~Z, 8 A0, with taken = sel ^ cond[4].
REQ-026 Select 9..15 SHALL give taken=0 and res_err_o=1 regardless of cond[4]; otherwise res_err_o=0.
REQ-027 RESP SHALL hold res_taken_o and res_err_o stable until res_ack_i, then go to IDLE; a new request is accepted at the earliest 1 cycle after the ack.
REQ-028 Minimum latency SHALL be 2 cycles: accept at t, res_vld_o=1 at t+2.
REQ-029 flush_i in WAIT or RESP SHALL return the FSM to IDLE next cycle and drop the result; flush_i in IDLE SHALL be ignored; pend_cnt and flags SHALL be unaffected by flush_i.
REQ-030 flush_i and res_ack_i asserted together SHALL act as flush.

Reset
REQ-031 With rst_n=0 at a clock edge: FSM=IDLE; pend_cnt, wait_cnt, flags, err_o, res_taken_o, res_err_o=0; res_vld_o=0, stall_o=0, br_rdy_o=1 after that edge.
REQ-032 Reset SHALL override all inputs, including mid-WAIT and mid-RESP, and SHALL discard any in-flight branch.

Verification
REQ-033 No pending; flags Z=1 loaded; br_cond=5'h01 at t -> res_vld_o=1, res_taken_o=1 at t+2; ack -> br_rdy_o=1 at t+3.
REQ-034 pend=2; br_cond=5'h11 (not Z) -> stall_o high until 2 flag_wr_i; last write Z=0 -> taken=1; a younger alu_issue_i during WAIT does not extend the wait.
REQ-035 Reset, then 4 alu_issue_i with MAX_PEND=3 -> pend_cnt_o=3, err_o=2'b01; flag_wr_i at pend 0 -> err_o[1]=1.
REQ-036 br_cond=5'h0C -> taken=0, res_err_o=1; br_cond=5'h06 with N=1, V=0, Z=0 -> taken=1.
REQ-037 flush_i in WAIT and rst_n=0 in RESP -> IDLE next cycle, no res_vld_o; pend_cnt_o preserved after the flush, 0 after the reset.
